pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter W, default 16, setting the width of the period and high-time counters and outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 16'hFFFF, giving the cycles without a rising edge before measurement stops; legal range 2..2^W-1.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port pwm_in, input, 1, an asynchronous PWM signal under measurement.
REQ-006 The block SHALL have port period, output, W, the last measured rise-to-rise interval in clk cycles.
REQ-007 The block SHALL have port high_time, output, W, the last measured high interval in clk cycles.
REQ-008 The block SHALL have port meas_valid, output, 1, a one-cycle pulse when period and high_time update.
REQ-009 The block SHALL have port duty, output, 8, equal to floor(high_time*256/period), saturated to 255.
REQ-010 The block SHALL have port duty_valid, output, 1, a one-cycle pulse when duty updates.
REQ-011 The block SHALL have port active, output, 1, high while a PWM signal is being tracked.
REQ-012 The block SHALL have port stuck_level, output, 1, the pwm_in level latched at timeout.

Function
REQ-013 pwm_in SHALL pass through a 2-flop synchronizer; rise = sync & ~sync_d and fall = ~sync & sync_d, both on the synchronized signal.
REQ-014 The FSM SHALL have states IDLE, HIGH and LOW, reset to IDLE.
REQ-015 IDLE: on rise, go to HIGH, load period_cnt=1 and high_cnt=1, set active=1, and publish nothing.
REQ-016 HIGH: on fall, go to LOW; on cycles without rise, period_cnt+1, and high_cnt+1 while sync=1.
REQ-017 LOW: on cycles without rise, period_cnt+1 and high_cnt holds.
REQ-018 On rise in HIGH or LOW, the block SHALL register period<=period_cnt and high_time<=high_cnt, pulse meas_valid next cycle, reload both counters to 1, and go to HIGH.
REQ-019 Under REQ-018, an input high for H cycles and low for L cycles SHALL yield period=H+L and high_time=H.
REQ-020 Latency SHALL be 3 clk edges from the edge that first samples the new pwm_in high to meas_valid=1.
REQ-021 Timeout: in HIGH or LOW, when period_cnt==TIMEOUT and there is no rise, the block SHALL go to IDLE, set active=0 and stuck_level=sync, and SHALL NOT pulse meas_valid.
REQ-022 On timeout, period, high_time and duty SHALL hold their last values.
REQ-023 Counters SHALL saturate at 2^W-1 and never wrap.
REQ-024 The divider is a sequential restoring divider with a (W+1)-bit remainder and a start/busy handshake.
REQ-025 The divider SHALL start on the meas_valid cycle only if not busy, and SHALL run 8 iterations, one quotient bit per cycle, MSB first.
REQ-026 duty_valid SHALL pulse exactly 8 cycles after the meas_valid that started the divider; duty updates on the same cycle.
REQ-027 If high_time==period at start, the result SHALL be 255; if period==0, no start SHALL occur.
REQ-028 A meas_valid while the divider is busy SHALL update period and high_time, and the divider SHALL ignore it and finish the current operation.
REQ-029 If rise and timeout coincide, rise SHALL win.
REQ-030 If fall and rise occur in the same cycle, which is impossible after synchronization, no special case is needed.

Reset
REQ-031 While rst=1 at a clk edge, all of these SHALL clear to 0: both synchronizer flops, sync_d, counters, FSM (IDLE), divider state and busy, period, high_time, duty, meas_valid, duty_valid, active and stuck_level.
REQ-032 Reset SHALL take priority over all events, and asserting it mid-measurement or mid-division SHALL abort with no pulses.
REQ-033 pwm_in=1 at reset release SHALL be seen as a rise, which starts tracking only (IDLE rule).

Verification
REQ-034 Repeating H=3, L=5 -> from the second rise on, period=8, high_time=3, meas_valid every 8 cycles, duty=96 with duty_valid 8 cycles after meas_valid.
REQ-035 Repeating H=1, L=2 -> period=3, high_time=1, duty=85; meas_valid events during busy do not restart the divider, and a duty_valid follows at most every 9 cycles.
REQ-036 TIMEOUT=20: run H=2, L=3, then hold pwm_in=1 -> 20 cycles after the last published rise active=0, stuck_level=1, no extra meas_valid, period=5 held; the next rise gives no publish, and the one after resumes.
REQ-037 Hold pwm_in=0 after activity with TIMEOUT=20 -> active=0, stuck_level=0.
REQ-038 Assert rst for one cycle mid-LOW and mid-division -> all outputs 0 the next cycle, no duty_valid, and the next two rises are needed for meas_valid.
REQ-039 H=10, L=0 (pwm_in constant 1 after one rise) with default TIMEOUT -> active stays 1 until period_cnt reaches 65535, then timeout with stuck_level=1.

Source files
------------

// File: rtl/pwm_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// pwm_capture : measures PWM period, high time and 8-bit duty of pwm_in.
// Revision    : 1.0
// ============================================================================
module pwm_capture #(
   parameter int               W       = 16,
   parameter logic [W-1:0]     TIMEOUT = 16'hFFFF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pwm_in,
   output logic [W-1:0] period,
   output logic [W-1:0] high_time,
   output logic         meas_valid,
   output logic [7:0]   duty,
   output logic         duty_valid,
   output logic         active,
   output logic         stuck_level
);

   localparam logic [1:0]   c_IDLE = 2'd0;
   localparam logic [1:0]   c_HIGH = 2'd1;
   localparam logic [1:0]   c_LOW  = 2'd2;
   localparam logic [W-1:0] c_ONE  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] c_MAX  = {W{1'b1}};

   logic         sync1_q, sync2_q, sync_d_q;
   logic [1:0]   state_q, state_d;
   logic [W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
   logic [W-1:0] period_q, period_d, high_q, high_d;
   logic         mv_q, mv_d, active_q, active_d, stuck_q, stuck_d;

   logic         busy_q, busy_d, sat_q, sat_d, dv_q, dv_d;
   logic [W:0]   rem_q, rem_d;
   logic [W-1:0] dvs_q, dvs_d;
   logic [6:0]   quo_q, quo_d;
   logic [2:0]   it_q, it_d;
   logic [7:0]   duty_q, duty_d;

   logic         w_rise, w_fall;
   logic [W-1:0] w_pcnt_inc, w_hcnt_inc;
   logic [W:0]   w_step_in, w_shift, w_rem_nxt;
   logic [W-1:0] w_step_dvs;
   logic         w_ge;

   assign w_rise     = sync2_q & ~sync_d_q;
   assign w_fall     = ~sync2_q & sync_d_q;
   assign w_pcnt_inc = (pcnt_q == c_MAX) ? pcnt_q : pcnt_q + c_ONE;
   assign w_hcnt_inc = (hcnt_q == c_MAX) ? hcnt_q : hcnt_q + c_ONE;

   always_comb begin
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      hcnt_d   = hcnt_q;
      period_d = period_q;
      high_d   = high_q;
      mv_d     = 1'b0;
      active_d = active_q;
      stuck_d  = stuck_q;
      case (state_q)
         c_IDLE: begin
            if (w_rise) begin
               state_d  = c_HIGH;
               pcnt_d   = c_ONE;
               hcnt_d   = c_ONE;
               active_d = 1'b1;
            end
         end
         c_HIGH, c_LOW: begin
            // A rise on the timeout cycle still publishes.
            if (w_rise) begin
               period_d = pcnt_q;
               high_d   = hcnt_q;
               mv_d     = 1'b1;
               pcnt_d   = c_ONE;
               hcnt_d   = c_ONE;
               state_d  = c_HIGH;
            end else if (pcnt_q == TIMEOUT) begin
               state_d  = c_IDLE;
               active_d = 1'b0;
               stuck_d  = sync2_q;
            end else begin
               pcnt_d = w_pcnt_inc;
               if (state_q == c_HIGH) begin
                  if (w_fall) begin
                     state_d = c_LOW;
                  end else if (sync2_q) begin
                     hcnt_d = w_hcnt_inc;
                  end
               end
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   // The start cycle performs the first of the 8 restoring iterations.
   assign w_step_in  = busy_q ? rem_q : {1'b0, high_q};
   assign w_step_dvs = busy_q ? dvs_q : period_q;
   assign w_shift    = w_step_in << 1;
   assign w_ge       = (w_shift >= {1'b0, w_step_dvs});
   assign w_rem_nxt  = w_ge ? (w_shift - {1'b0, w_step_dvs}) : w_shift;

   always_comb begin
      busy_d = busy_q;
      sat_d  = sat_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      quo_d  = quo_q;
      it_d   = it_q;
      duty_d = duty_q;
      dv_d   = 1'b0;
      if (busy_q) begin
         rem_d = w_rem_nxt;
         quo_d = {quo_q[5:0], w_ge};
         if (it_q == 3'd7) begin
            busy_d = 1'b0;
            dv_d   = 1'b1;
            duty_d = sat_q ? 8'hFF : {quo_q, w_ge};
         end else begin
            it_d = it_q + 3'd1;
         end
      end else if (mv_q && (period_q != '0)) begin
         busy_d = 1'b1;
         sat_d  = (high_q >= period_q);
         dvs_d  = period_q;
         rem_d  = w_rem_nxt;
         quo_d  = {6'd0, w_ge};
         it_d   = 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         sync_d_q <= 1'b0;
         state_q  <= c_IDLE;
         pcnt_q   <= '0;
         hcnt_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         mv_q     <= 1'b0;
         active_q <= 1'b0;
         stuck_q  <= 1'b0;
         busy_q   <= 1'b0;
         sat_q    <= 1'b0;
         rem_q    <= '0;
         dvs_q    <= '0;
         quo_q    <= '0;
         it_q     <= '0;
         duty_q   <= '0;
         dv_q     <= 1'b0;
      end else begin
         sync1_q  <= pwm_in;
         sync2_q  <= sync1_q;
         sync_d_q <= sync2_q;
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         hcnt_q   <= hcnt_d;
         period_q <= period_d;
         high_q   <= high_d;
         mv_q     <= mv_d;
         active_q <= active_d;
         stuck_q  <= stuck_d;
         busy_q   <= busy_d;
         sat_q    <= sat_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         quo_q    <= quo_d;
         it_q     <= it_d;
         duty_q   <= duty_d;
         dv_q     <= dv_d;
      end
   end

   assign period      = period_q;
   assign high_time   = high_q;
   assign meas_valid  = mv_q;
   assign duty        = duty_q;
   assign duty_valid  = dv_q;
   assign active      = active_q;
   assign stuck_level = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pwm_capture : self-checking bench for pwm_capture.
// Revision       : 1.0
// ============================================================================
module tb_pwm_capture;

   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pwm_in = 1'b0;
   logic [15:0] period, high_time;
   logic        meas_valid, duty_valid, active, stuck_level;
   logic [7:0]  duty;

   logic        pwm8 = 1'b0;
   logic [7:0]  period8, high8, duty8;
   logic        mv8, dv8, act8, stk8;

   pwm_capture #(.W(16), .TIMEOUT(16'd20)) dut (
      .clk(clk), .rst(rst), .pwm_in(pwm_in),
      .period(period), .high_time(high_time), .meas_valid(meas_valid),
      .duty(duty), .duty_valid(duty_valid), .active(active),
      .stuck_level(stuck_level)
   );

   pwm_capture #(.W(8), .TIMEOUT(8'hFF)) dut8 (
      .clk(clk), .rst(rst), .pwm_in(pwm8),
      .period(period8), .high_time(high8), .meas_valid(mv8),
      .duty(duty8), .duty_valid(dv8), .active(act8),
      .stuck_level(stk8)
   );

   always #5 clk = ~clk;

   logic [43:0] out_vec;
   assign out_vec = {period, high_time, meas_valid, duty, duty_valid, active, stuck_level};

   int errors = 0;
   int checks = 0;
   int mv_cnt = 0;
   int dv_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Event-level reference: rises/falls in sample time, divider as a fixed delay.
   bit x1, x2, x3, trk, div_run;
   int cyc, j0, fall_at, div_start, div_res;
   int e_period, e_high, e_duty;
   bit e_mv, e_dv, e_act, e_stk;

   task automatic model_step(input bit r, input bit p);
      if (r) begin
         x1 = 0; x2 = 0; x3 = 0; trk = 0; div_run = 0; cyc = 0;
         e_period = 0; e_high = 0; e_duty = 0;
         e_mv = 0; e_dv = 0; e_act = 0; e_stk = 0;
         return;
      end
      e_mv = 0;
      e_dv = 0;
      if (div_run && cyc == div_start + 8) begin
         e_duty  = div_res;
         e_dv    = 1;
         div_run = 0;
      end
      if (x2 && !x3) begin
         if (trk) begin
            e_period = cyc - j0;
            e_high   = fall_at - j0;
            e_mv     = 1;
            if (!div_run && e_period != 0) begin
               div_run   = 1;
               div_start = cyc;
               div_res   = (e_high * 256) / e_period;
               if (div_res > 255) div_res = 255;
            end
         end else begin
            trk   = 1;
            e_act = 1;
         end
         j0      = cyc;
         fall_at = -1;
      end else if (trk) begin
         if (cyc - j0 == TO) begin
            trk   = 0;
            e_act = 0;
            e_stk = x2;
         end else if (!x2 && x3 && fall_at < 0) begin
            fall_at = cyc;
         end
      end
      x3 = x2; x2 = x1; x1 = p;
      cyc++;
   endtask

   initial begin
      bit r_s, p_s;
      logic [43:0] ev;
      forever begin
         @(posedge clk);
         r_s = rst;
         p_s = pwm_in;
         #1;
         model_step(r_s, p_s);
         if (meas_valid === 1'b1) mv_cnt++;
         if (duty_valid === 1'b1) dv_cnt++;
         ev = {e_period[15:0], e_high[15:0], e_mv, e_duty[7:0], e_dv, e_act, e_stk};
         checks++;
         if (out_vec !== ev) begin
            errors++;
            $display("FAIL monitor t=%0t got per=%0d hi=%0d mv=%b duty=%0d dv=%b act=%b stk=%b expected per=%0d hi=%0d mv=%b duty=%0d dv=%b act=%b stk=%b",
                     $time, period, high_time, meas_valid, duty, duty_valid, active, stuck_level,
                     e_period, e_high, e_mv, e_duty, e_dv, e_act, e_stk);
         end
      end
   end

   task automatic drive(input bit v, input int n);
      repeat (n) begin
         @(negedge clk);
         pwm_in = v;
      end
   endtask

   task automatic pulse(input int h, input int l);
      drive(1'b1, h);
      drive(1'b0, l);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      int h;
      int l;
      int per;
      int hi;
      int dty;
   } row_t;

   row_t rows[7];

   initial begin
      int c0, k;
      rows[0] = '{3, 5,  8, 3,  96};
      rows[1] = '{1, 2,  3, 1,  85};
      rows[2] = '{2, 2,  4, 2, 128};
      rows[3] = '{4, 1,  5, 4, 204};
      rows[4] = '{1, 9, 10, 1,  25};
      rows[5] = '{7, 9, 16, 7, 112};
      rows[6] = '{8, 1,  9, 8, 227};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_outputs", {20'd0, out_vec}, 64'd0);
      check("reset_outputs_w8", {act8, stk8, mv8, dv8, period8, high8, duty8}, 64'd0);

      // Each row ends with a long low hold: measurement values must survive the timeout.
      for (int i = 0; i < 7; i++) begin
         repeat (5) pulse(rows[i].h, rows[i].l);
         drive(1'b0, 30);
         check($sformatf("row%0d_period", i), period, rows[i].per);
         check($sformatf("row%0d_high", i), high_time, rows[i].hi);
         check($sformatf("row%0d_duty", i), duty, rows[i].dty);
         check($sformatf("row%0d_active", i), active, 0);
         check($sformatf("row%0d_stuck", i), stuck_level, 0);
      end

      // Stuck high, then restart needs two rises.
      repeat (4) pulse(2, 3);
      drive(1'b1, 30);
      check("stuck_hi_active", active, 0);
      check("stuck_hi_level", stuck_level, 1);
      check("stuck_hi_period", period, 5);
      check("stuck_hi_high", high_time, 2);
      drive(1'b0, 3);
      c0 = mv_cnt;
      pulse(2, 3);
      check("restart_first_rise_mv", mv_cnt - c0, 0);
      pulse(2, 3);
      check("restart_second_rise_mv", mv_cnt - c0, 1);
      drive(1'b0, 30);
      check("stuck_lo_level", stuck_level, 0);

      // Reset in the low phase.
      repeat (3) pulse(3, 5);
      drive(1'b1, 3);
      drive(1'b0, 2);
      do_reset(1);
      check("rst_low_outputs", {20'd0, out_vec}, 64'd0);
      c0 = mv_cnt;
      pulse(3, 5);
      check("rst_low_first_rise_mv", mv_cnt - c0, 0);
      pulse(3, 5);
      check("rst_low_second_rise_mv", mv_cnt - c0, 1);

      // Reset while the divider is running.
      pulse(3, 5);
      drive(1'b1, 1);
      k = 0;
      while (meas_valid !== 1'b1 && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("div_mv_seen", meas_valid, 1);
      repeat (2) @(negedge clk);
      do_reset(1);
      check("rst_div_outputs", {20'd0, out_vec}, 64'd0);
      c0 = dv_cnt;
      drive(1'b0, 12);
      check("rst_div_no_dv", dv_cnt - c0, 0);

      // Randomised traffic against the reference.
      for (int i = 0; i < 250; i++) begin
         k = $urandom_range(0, 40);
         if (k == 0) do_reset(1);
         else if (k < 4) drive(1'(k & 1), $urandom_range(15, 30));
         else pulse($urandom_range(1, 8), $urandom_range(1, 8));
      end
      drive(1'b0, 30);

      // Narrow instance: counter saturation coincides with timeout.
      @(negedge clk);
      pwm8 = 1'b1;
      k = 0;
      while (act8 !== 1'b1 && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("w8_active_on_rise", act8, 1);
      repeat (254) @(posedge clk);
      #1;
      check("w8_active_before_timeout", act8, 1);
      @(posedge clk);
      #1;
      check("w8_active_after_timeout", act8, 0);
      check("w8_stuck_level", stk8, 1);
      check("w8_no_publish", {mv8, period8, high8}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
